// File: rtl/lsf_hist_pkg.sv
// Shared definitions for the LSF multi-hit r-bin histogram.
//   state_t      : event FSM states
//   DRAIN_CYCLES : cycles spent in DRAIN so the last hits reach the running max
//   sat_add      : saturating counter addition
//   sat_hit      : true when an addition reaches or passes full scale
//   hit_valid    : MSB-flag and range check of a raw hit index
package lsf_hist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_DRAIN,
    ST_REPORT
  } state_t;

  localparam int DRAIN_CYCLES = 2;

  function automatic logic [31:0] sat_add(input logic [31:0] old_val,
                                          input logic [31:0] incr,
                                          input int          cw);
    logic [31:0] full;
    logic [31:0] sum;
    full = (32'd1 << cw) - 32'd1;
    sum  = old_val + incr;
    return (sum >= full) ? full : sum;
  endfunction

  function automatic logic sat_hit(input logic [31:0] old_val,
                                   input logic [31:0] incr,
                                   input int          cw);
    logic [31:0] full;
    full = (32'd1 << cw) - 32'd1;
    return (old_val + incr) >= full;
  endfunction

  // bin carries the no-bin flag in bit width-1; the remaining bits are the index.
  function automatic logic hit_valid(input logic [31:0] bin,
                                     input int          width,
                                     input int          rbins);
    logic [31:0] idx;
    idx = bin & ((32'd1 << (width - 1)) - 32'd1);
    return !bin[width-1] && (idx < 32'(rbins));
  endfunction

endpackage

// File: rtl/lsf_hist_bin_array.sv
// Saturating per-bin counter array.
//   clk, rst : clock, asynchronous active-high reset (zeroes all counters)
//   clear    : synchronous clear of all counters
//   wr_vld   : per-port write request (already qualified by the caller)
//   wr_idx   : per-port bin index
//   wr_first : ports that actually write (lowest port of each distinct index)
//   sat_evt  : some written counter reached full scale this cycle
//   rd_idx   : per-port read index
//   rd_cnt   : per-port counter value (reads registered state)
import lsf_hist_pkg::*;

module lsf_hist_bin_array #(
  parameter int NUM_HITS    = 4,
  parameter int RBINS       = 128,
  parameter int IDX_W       = 7,
  parameter int COUNT_WIDTH = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  clear,
  input  logic [NUM_HITS-1:0]                   wr_vld,
  input  logic [NUM_HITS-1:0][IDX_W-1:0]        wr_idx,
  output logic [NUM_HITS-1:0]                   wr_first,
  output logic                                  sat_evt,
  input  logic [NUM_HITS-1:0][IDX_W-1:0]        rd_idx,
  output logic [NUM_HITS-1:0][COUNT_WIDTH-1:0]  rd_cnt
);

  logic [COUNT_WIDTH-1:0] cnt [RBINS];
  logic [NUM_HITS-1:0][COUNT_WIDTH-1:0] new_cnt;

  // Ports sharing an index merge: the lowest such port writes old + (number of
  // ports on that index); the others are suppressed so each bin has one writer.
  always_comb begin
    wr_first = '0;
    new_cnt  = '0;
    sat_evt  = 1'b0;
    for (int i = 0; i < NUM_HITS; i++) begin
      int incr;
      logic first;
      incr  = 0;
      first = wr_vld[i];
      for (int j = 0; j < NUM_HITS; j++) begin
        if (wr_vld[j] && (wr_idx[j] == wr_idx[i])) begin
          incr = incr + 1;
          if (j < i) first = 1'b0;
        end
      end
      wr_first[i] = first;
      new_cnt[i]  = COUNT_WIDTH'(sat_add(32'(cnt[wr_idx[i]]), 32'(incr), COUNT_WIDTH));
      if (first && sat_hit(32'(cnt[wr_idx[i]]), 32'(incr), COUNT_WIDTH)) sat_evt = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < RBINS; b++) cnt[b] <= '0;
    end else if (clear) begin
      for (int b = 0; b < RBINS; b++) cnt[b] <= '0;
    end else begin
      for (int i = 0; i < NUM_HITS; i++) begin
        if (wr_first[i]) cnt[wr_idx[i]] <= new_cnt[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_HITS; i++) rd_cnt[i] = cnt[rd_idx[i]];
  end

endmodule

// File: rtl/lsf_histogram_multi.sv
// LSF r-bin histogram updater, NUM_HITS hits per cycle.
//   clk, rst   : clock, asynchronous active-high reset
//   enable     : gates hit acceptance
//   clear_i    : start a new event (clears histogram, enters ACCUM)
//   hit_vld    : hit_bin valid this cycle
//   hit_bin    : NUM_HITS r-bin indices, MSB=1 means no bin
//   event_done : last hits of the event are presented
//   min_count  : threshold qualifying max_found
//   busy       : FSM not idle
//   max_update : running maximum changed
//   max_rbin   : running / final maximum bin
//   max_count  : running / final maximum count
//   max_vld    : end-of-event strobe
//   max_found  : max_count >= min_count and non-zero, valid with max_vld
//   saturated  : sticky, a counter reached full scale this event
import lsf_hist_pkg::*;

module lsf_histogram_multi #(
  parameter int NUM_HITS    = 4,
  parameter int RBINS       = 128,
  parameter int RBIN_WIDTH  = 8,
  parameter int COUNT_WIDTH = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 enable,
  input  logic                                 clear_i,
  input  logic                                 hit_vld,
  input  logic [NUM_HITS-1:0][RBIN_WIDTH-1:0]  hit_bin,
  input  logic                                 event_done,
  input  logic [COUNT_WIDTH-1:0]               min_count,
  output logic                                 busy,
  output logic                                 max_update,
  output logic [RBIN_WIDTH-2:0]                max_rbin,
  output logic [COUNT_WIDTH-1:0]               max_count,
  output logic                                 max_vld,
  output logic                                 max_found,
  output logic                                 saturated
);

  localparam int IDX_W = RBIN_WIDTH - 1;

  state_t                                state;
  logic [1:0]                            drain_cnt;
  logic                                  accept;
  logic [NUM_HITS-1:0]                   hit_ok;
  logic [NUM_HITS-1:0][IDX_W-1:0]        hit_idx;
  logic [NUM_HITS-1:0]                   wr_first;
  logic                                  sat_evt;
  logic [NUM_HITS-1:0]                   vld_p1;
  logic [NUM_HITS-1:0][IDX_W-1:0]        idx_p1;
  logic [NUM_HITS-1:0][COUNT_WIDTH-1:0]  rd_cnt_p1;
  logic                                  best_vld;
  logic [IDX_W-1:0]                      best_idx;
  logic [COUNT_WIDTH-1:0]                best_cnt;
  logic                                  max_vld_q;
  logic                                  max_found_q;

  // ---- stage 0: qualify hits, merge and write counters ----
  // Hits in the clear cycle are dropped, so clear_i also blocks acceptance.
  assign accept = hit_vld & enable & (state == ST_ACCUM) & ~clear_i;

  always_comb begin
    for (int i = 0; i < NUM_HITS; i++) begin
      hit_idx[i] = hit_bin[i][IDX_W-1:0];
      hit_ok[i]  = accept && hit_valid(32'(hit_bin[i]), RBIN_WIDTH, RBINS);
    end
  end

  lsf_hist_bin_array #(
    .NUM_HITS    (NUM_HITS),
    .RBINS       (RBINS),
    .IDX_W       (IDX_W),
    .COUNT_WIDTH (COUNT_WIDTH)
  ) u_bins (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear_i),
    .wr_vld   (hit_ok),
    .wr_idx   (hit_idx),
    .wr_first (wr_first),
    .sat_evt  (sat_evt),
    .rd_idx   (idx_p1),
    .rd_cnt   (rd_cnt_p1)
  );

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_HITS; i++) idx_p1[i] <= wr_first[i] ? hit_idx[i] : '0;
  end

  // ---- stage 1: read post-update counts, pick the best written bin ----
  // Strict compare while scanning upward keeps the lower port on a tie.
  always_comb begin
    best_vld = 1'b0;
    best_idx = '0;
    best_cnt = '0;
    for (int i = 0; i < NUM_HITS; i++) begin
      if (vld_p1[i] && (!best_vld || (rd_cnt_p1[i] > best_cnt))) begin
        best_vld = 1'b1;
        best_idx = idx_p1[i];
        best_cnt = rd_cnt_p1[i];
      end
    end
  end

  // ---- stage 2: running max registers and event FSM ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      drain_cnt   <= '0;
      vld_p1      <= '0;
      max_rbin    <= '0;
      max_count   <= '0;
      max_update  <= 1'b0;
      saturated   <= 1'b0;
      max_vld_q   <= 1'b0;
      max_found_q <= 1'b0;
    end else begin
      max_update  <= 1'b0;
      max_vld_q   <= 1'b0;
      max_found_q <= 1'b0;
      if (clear_i) begin
        state     <= ST_ACCUM;
        drain_cnt <= '0;
        vld_p1    <= '0;
        max_rbin  <= '0;
        max_count <= '0;
        saturated <= 1'b0;
      end else begin
        vld_p1    <= wr_first;
        saturated <= saturated | sat_evt;
        // Strictly greater: the first bin to reach a count keeps the maximum.
        if (best_vld && (best_cnt > max_count)) begin
          max_rbin   <= best_idx;
          max_count  <= best_cnt;
          max_update <= 1'b1;
        end
        case (state)
          ST_IDLE: ;
          ST_ACCUM: begin
            if (event_done) begin
              state     <= ST_DRAIN;
              drain_cnt <= '0;
            end
          end
          ST_DRAIN: begin
            if (drain_cnt == 2'(DRAIN_CYCLES - 1)) begin
              state       <= ST_REPORT;
              max_vld_q   <= 1'b1;
              max_found_q <= (max_count >= min_count) && (max_count != '0);
            end else begin
              drain_cnt <= drain_cnt + 2'd1;
            end
          end
          ST_REPORT: state <= ST_IDLE;
          default:   state <= ST_IDLE;
        endcase
      end
    end
  end

  assign busy = (state != ST_IDLE);

  // A clear arriving during REPORT aborts the event, so it also masks the strobe.
  assign max_vld   = max_vld_q & ~clear_i;
  assign max_found = max_found_q & ~clear_i;

endmodule

// File: tb/tb_lsf_histogram_multi.sv
module tb_lsf_histogram_multi;

  localparam int NH = 4;
  localparam int RB = 100;
  localparam int RW = 8;
  localparam int CW = 4;
  localparam logic [7:0] INV = 8'h80;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   enable;
  logic                   clear_i;
  logic                   hit_vld;
  logic [NH-1:0][RW-1:0]  hit_bin;
  logic                   event_done;
  logic [CW-1:0]          min_count;
  logic                   busy;
  logic                   max_update;
  logic [RW-2:0]          max_rbin;
  logic [CW-1:0]          max_count;
  logic                   max_vld;
  logic                   max_found;
  logic                   saturated;

  typedef struct { int rbin; int cnt; } upd_t;
  typedef struct { int found; int rbin; int cnt; } rpt_t;

  upd_t upd_q[$];
  rpt_t rpt_q[$];
  upd_t ue;
  rpt_t re;
  int   total = 0;
  int   bad   = 0;

  lsf_histogram_multi #(
    .NUM_HITS    (NH),
    .RBINS       (RB),
    .RBIN_WIDTH  (RW),
    .COUNT_WIDTH (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .clear_i    (clear_i),
    .hit_vld    (hit_vld),
    .hit_bin    (hit_bin),
    .event_done (event_done),
    .min_count  (min_count),
    .busy       (busy),
    .max_update (max_update),
    .max_rbin   (max_rbin),
    .max_count  (max_count),
    .max_vld    (max_vld),
    .max_found  (max_found),
    .saturated  (saturated)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic exp_upd(input int rbin, input int cnt);
    upd_t u;
    u.rbin = rbin;
    u.cnt  = cnt;
    upd_q.push_back(u);
  endtask

  task automatic exp_rpt(input int found, input int rbin, input int cnt);
    rpt_t r;
    r.found = found;
    r.rbin  = rbin;
    r.cnt   = cnt;
    rpt_q.push_back(r);
  endtask

  // One clock of stimulus; inputs change 1 time unit after the rising edge.
  task automatic step(input logic vld, input logic [7:0] b0, input logic [7:0] b1,
                      input logic [7:0] b2, input logic [7:0] b3,
                      input logic done, input logic clr);
    hit_vld    = vld;
    hit_bin    = {b3, b2, b1, b0};
    event_done = done;
    clear_i    = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, INV, INV, INV, INV, 1'b0, 1'b0);
  endtask

  task automatic do_clear();
    step(1'b0, INV, INV, INV, INV, 1'b0, 1'b1);
  endtask

  // Monitor: every max_update / max_vld must match the next queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (max_update) begin
        if (upd_q.size() == 0) begin
          chk("unexpected_max_update", 1, 0);
        end else begin
          ue = upd_q.pop_front();
          chk("upd_rbin", int'(max_rbin), ue.rbin);
          chk("upd_count", int'(max_count), ue.cnt);
        end
      end
      if (max_vld) begin
        if (rpt_q.size() == 0) begin
          chk("unexpected_max_vld", 1, 0);
        end else begin
          re = rpt_q.pop_front();
          chk("rpt_found", int'(max_found), re.found);
          chk("rpt_rbin", int'(max_rbin), re.rbin);
          chk("rpt_count", int'(max_count), re.cnt);
        end
      end else begin
        if (max_found) chk("max_found_without_vld", 1, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    enable     = 1'b1;
    clear_i    = 1'b0;
    hit_vld    = 1'b0;
    hit_bin    = {INV, INV, INV, INV};
    event_done = 1'b0;
    min_count  = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_busy", int'(busy), 0);
    chk("rst_max_update", int'(max_update), 0);
    chk("rst_max_rbin", int'(max_rbin), 0);
    chk("rst_max_count", int'(max_count), 0);
    chk("rst_max_vld", int'(max_vld), 0);
    chk("rst_saturated", int'(saturated), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Three hits on bin 5 in one cycle merge into +3.
    min_count = 4'd2;
    do_clear();
    chk("t1_busy", int'(busy), 1);
    exp_upd(5, 3);
    exp_rpt(1, 5, 3);
    step(1'b1, 8'd5, 8'd5, 8'd5, INV, 1'b1, 1'b0);
    idle(5);
    chk("t1_idle_busy", int'(busy), 0);
    chk("t1_hold_rbin", int'(max_rbin), 5);
    chk("t1_hold_count", int'(max_count), 3);

    // Tie at count 1 goes to the lower port (bin 9); bin 3 then reaches 2.
    min_count = 4'd1;
    do_clear();
    chk("t2_cleared_count", int'(max_count), 0);
    exp_upd(9, 1);
    step(1'b1, 8'd9, 8'd3, INV, INV, 1'b0, 1'b0);
    idle(1);
    exp_upd(3, 2);
    exp_rpt(1, 3, 2);
    step(1'b1, 8'd3, INV, INV, INV, 1'b1, 1'b0);
    idle(5);

    // Saturation: 4,8,12,15 then stuck at 15 with no further updates.
    do_clear();
    exp_upd(7, 4);
    exp_upd(7, 8);
    exp_upd(7, 12);
    exp_upd(7, 15);
    for (int k = 0; k < 3; k++) step(1'b1, 8'd7, 8'd7, 8'd7, 8'd7, 1'b0, 1'b0);
    chk("t3_not_sat_yet", int'(saturated), 0);
    for (int k = 0; k < 2; k++) step(1'b1, 8'd7, 8'd7, 8'd7, 8'd7, 1'b0, 1'b0);
    chk("t3_saturated", int'(saturated), 1);
    exp_rpt(1, 7, 15);
    step(1'b1, 8'd7, 8'd7, 8'd7, 8'd7, 1'b1, 1'b0);
    idle(5);
    chk("t3_sat_sticky", int'(saturated), 1);
    chk("t3_final_count", int'(max_count), 15);

    // Threshold not met: single hit, min_count 4.
    min_count = 4'd4;
    do_clear();
    chk("t4_sat_cleared", int'(saturated), 0);
    exp_upd(20, 1);
    exp_rpt(0, 20, 1);
    step(1'b1, 8'd20, INV, INV, INV, 1'b1, 1'b0);
    idle(5);

    // Abort with clear in the second DRAIN cycle: no report.
    min_count = 4'd1;
    do_clear();
    exp_upd(11, 2);
    step(1'b1, 8'd11, 8'd11, INV, INV, 1'b1, 1'b0);
    idle(1);
    do_clear();
    chk("t5_abort_count", int'(max_count), 0);
    chk("t5_abort_busy", int'(busy), 1);
    exp_upd(11, 1);
    exp_rpt(1, 11, 1);
    step(1'b1, 8'd11, INV, INV, INV, 1'b1, 1'b0);
    idle(5);
    chk("t5_new_event_sat", int'(saturated), 0);

    // Asynchronous reset mid-ACCUM with hits present.
    do_clear();
    exp_upd(30, 1);
    step(1'b1, 8'd30, INV, INV, INV, 1'b0, 1'b0);
    idle(2);
    chk("t6_pre_count", int'(max_count), 1);
    hit_vld = 1'b1;
    hit_bin = {8'd30, 8'd30, 8'd30, 8'd30};
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_busy", int'(busy), 0);
    chk("t6_async_count", int'(max_count), 0);
    chk("t6_async_rbin", int'(max_rbin), 0);
    chk("t6_async_update", int'(max_update), 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    step(1'b1, 8'd5, 8'h7F, 8'd6, INV, 1'b1, 1'b0);
    idle(4);
    chk("t6_ignored_busy", int'(busy), 0);
    chk("t6_ignored_count", int'(max_count), 0);
    // Out-of-range indices 127 and 100 with RBINS=100 must not count.
    min_count = 4'd0;
    do_clear();
    exp_rpt(0, 0, 0);
    step(1'b1, 8'h7F, 8'd100, INV, INV, 1'b1, 1'b0);
    idle(5);
    chk("t6_range_count", int'(max_count), 0);

    chk("upd_queue_drained", upd_q.size(), 0);
    chk("rpt_queue_drained", rpt_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
